// File: rtl/bsg_fma_pkg.sv
// rtl/bsg_fma_pkg.sv - shared opcodes, operand widths and op struct for the shared FMA controller
package bsg_fma_pkg;

    localparam int op_ab_width_lp = 32;
    localparam int op_c_width_lp  = 48;

    localparam logic e_fma_op_mul = 1'b0;
    localparam logic e_fma_op_add = 1'b1;

    typedef struct packed {
        logic                      opcode;
        logic [op_ab_width_lp-1:0] a;
        logic [op_ab_width_lp-1:0] b;
        logic [op_c_width_lp-1:0]  c;
    } fma_op_s;

endpackage

// File: rtl/bsg_fma_rr_arb.sv
// rtl/bsg_fma_rr_arb.sv - round-robin arbiter with a rotating priority pointer
module bsg_fma_rr_arb #(
    parameter int num_req_p    = 4,
    parameter int tag_width_lp = $clog2(num_req_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_req_p-1:0]    reqs_i,
    input  logic                    en_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic                    grant_v_o,
    output logic [tag_width_lp-1:0] grant_id_o
);

    logic [tag_width_lp-1:0] ptr_r;
    logic [num_req_p-1:0]    hi_mask;
    logic [num_req_p-1:0]    reqs_hi;
    logic [num_req_p-1:0]    pick;
    logic [tag_width_lp-1:0] grant_id;
    logic                    any_req;

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < num_req_p; i++) begin
            hi_mask[i] = (tag_width_lp'(i) >= ptr_r);
        end
    end

    assign reqs_hi = reqs_i & hi_mask;
    assign pick    = (|reqs_hi) ? reqs_hi : reqs_i;
    assign any_req = |reqs_i;

    always_comb begin
        grant_id = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_id = tag_width_lp'(i);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            grant_o[i] = en_i && any_req && (grant_id == tag_width_lp'(i));
        end
    end

    assign grant_v_o  = en_i && any_req;
    assign grant_id_o = grant_id;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (grant_v_o) begin
            if (grant_id == tag_width_lp'(num_req_p - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_id + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_fma_share_ctrl.sv
// rtl/bsg_fma_share_ctrl.sv - shares one pipelined FMA datapath among requesters with tagged responses
module bsg_fma_share_ctrl
    import bsg_fma_pkg::*;
#(
    parameter int num_req_p     = 4,
    parameter int fma_latency_p = 3,
    localparam int tag_width_lp = $clog2(num_req_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [num_req_p-1:0]        req_v_i,
    input  logic [num_req_p-1:0]        req_opcode_i,
    input  logic [32*num_req_p-1:0]     req_a_i,
    input  logic [32*num_req_p-1:0]     req_b_i,
    input  logic [48*num_req_p-1:0]     req_c_i,
    output logic [num_req_p-1:0]        req_yumi_o,
    input  logic                        drain_i,
    output logic                        fma_v_o,
    output logic                        fma_opcode_o,
    output logic [31:0]                 fma_a_o,
    output logic [31:0]                 fma_b_o,
    output logic [47:0]                 fma_c_o,
    input  logic                        fma_v_i,
    input  logic [47:0]                 fma_res_i,
    input  logic                        fma_type_i,
    output logic [num_req_p-1:0]        resp_v_o,
    output logic [47:0]                 resp_res_o,
    output logic                        resp_type_o,
    output logic                        idle_o,
    output logic                        error_o
);

    logic                    grant_v;
    logic [tag_width_lp-1:0] grant_id;
    fma_op_s                 sel_op;

    fma_op_s                 issue_r;
    logic                    fma_v_r;
    logic [tag_width_lp-1:0] issue_tag_r;

    logic [fma_latency_p-1:0] pipe_v_r;
    logic [tag_width_lp-1:0]  pipe_tag_r [fma_latency_p];
    logic                     tail_v;
    logic [tag_width_lp-1:0]  tail_tag;

    logic [num_req_p-1:0]    resp_v_r;
    logic [47:0]             resp_res_r;
    logic                    resp_type_r;
    logic                    error_r;
    logic [num_req_p-1:0]    resp_onehot;

    // Holding reset also blocks grants so no yumi escapes while the block is cleared.
    bsg_fma_rr_arb #(
        .num_req_p    (num_req_p),
        .tag_width_lp (tag_width_lp)
    ) arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .reqs_i     (req_v_i),
        .en_i       (~drain_i & ~reset_i),
        .grant_o    (req_yumi_o),
        .grant_v_o  (grant_v),
        .grant_id_o (grant_id)
    );

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_id == tag_width_lp'(i)) begin
                sel_op.opcode = req_opcode_i[i];
                sel_op.a      = req_a_i[32*i +: 32];
                sel_op.b      = req_b_i[32*i +: 32];
                sel_op.c      = req_c_i[48*i +: 48];
            end
        end
    end

    // Operands only load on a grant so the datapath inputs stay quiet between ops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            issue_r     <= '0;
            fma_v_r     <= 1'b0;
            issue_tag_r <= '0;
        end else begin
            fma_v_r <= grant_v;
            if (grant_v) begin
                issue_r     <= sel_op;
                issue_tag_r <= grant_id;
            end
        end
    end

    assign fma_v_o      = fma_v_r;
    assign fma_opcode_o = issue_r.opcode;
    assign fma_a_o      = issue_r.a;
    assign fma_b_o      = issue_r.b;
    assign fma_c_o      = issue_r.c;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pipe_v_r <= '0;
            for (int s = 0; s < fma_latency_p; s++) begin
                pipe_tag_r[s] <= '0;
            end
        end else begin
            pipe_v_r[0]   <= fma_v_r;
            pipe_tag_r[0] <= issue_tag_r;
            for (int s = 1; s < fma_latency_p; s++) begin
                pipe_v_r[s]   <= pipe_v_r[s-1];
                pipe_tag_r[s] <= pipe_tag_r[s-1];
            end
        end
    end

    assign tail_v   = pipe_v_r[fma_latency_p-1];
    assign tail_tag = pipe_tag_r[fma_latency_p-1];

    always_comb begin
        resp_onehot = '0;
        for (int i = 0; i < num_req_p; i++) begin
            resp_onehot[i] = (tail_tag == tag_width_lp'(i));
        end
    end

    // A datapath result without a matching tag (or vice versa) is dropped and flagged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_v_r    <= '0;
            resp_res_r  <= '0;
            resp_type_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            if (fma_v_i && tail_v) begin
                resp_v_r    <= resp_onehot;
                resp_res_r  <= fma_res_i;
                resp_type_r <= fma_type_i;
            end else begin
                resp_v_r    <= '0;
            end
            if (fma_v_i != tail_v) begin
                error_r <= 1'b1;
            end
        end
    end

    assign resp_v_o    = resp_v_r;
    assign resp_res_o  = resp_res_r;
    assign resp_type_o = resp_type_r;
    assign error_o     = error_r;
    assign idle_o      = ~fma_v_r & ~(|pipe_v_r);

endmodule

// File: tb/tb_bsg_fma_share_ctrl.sv
// tb/tb_bsg_fma_share_ctrl.sv - directed self-checking bench for bsg_fma_share_ctrl with a datapath stub
module tb_bsg_fma_share_ctrl;

    localparam int n_lp = 4;
    localparam int l_lp = 3;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [n_lp-1:0]   req_v, req_opcode;
    logic [32*n_lp-1:0] req_a, req_b;
    logic [48*n_lp-1:0] req_c;
    logic [n_lp-1:0]   req_yumi;
    logic              drain;
    logic              fma_v_o, fma_opcode_o;
    logic [31:0]       fma_a_o, fma_b_o;
    logic [47:0]       fma_c_o;
    logic              fma_v_i, fma_type_i;
    logic [47:0]       fma_res_i;
    logic [n_lp-1:0]   resp_v;
    logic [47:0]       resp_res;
    logic              resp_type, idle, error;

    logic              inject;
    logic [l_lp-1:0]   stub_v;
    logic [l_lp-1:0]   stub_t;
    logic [47:0]       stub_r [l_lp];
    logic [47:0]       stub_calc;

    int total = 0;
    int bad   = 0;
    logic [n_lp-1:0] seen;

    always #5 clk = ~clk;

    bsg_fma_share_ctrl #(.num_req_p(n_lp), .fma_latency_p(l_lp)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v), .req_opcode_i(req_opcode),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
        .req_yumi_o(req_yumi), .drain_i(drain),
        .fma_v_o(fma_v_o), .fma_opcode_o(fma_opcode_o),
        .fma_a_o(fma_a_o), .fma_b_o(fma_b_o), .fma_c_o(fma_c_o),
        .fma_v_i(fma_v_i), .fma_res_i(fma_res_i), .fma_type_i(fma_type_i),
        .resp_v_o(resp_v), .resp_res_o(resp_res), .resp_type_o(resp_type),
        .idle_o(idle), .error_o(error)
    );

    // Fixed-latency datapath stub
    always_comb begin
        if (fma_opcode_o)
            stub_calc = 48'(fma_a_o[23:0]) + 48'(fma_b_o[23:0]) + fma_c_o;
        else
            stub_calc = 48'(fma_a_o) * 48'(fma_b_o);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            stub_v <= '0;
            stub_t <= '0;
            for (int s = 0; s < l_lp; s++) stub_r[s] <= '0;
        end else begin
            stub_v[0] <= fma_v_o;
            stub_t[0] <= fma_opcode_o;
            stub_r[0] <= stub_calc;
            for (int s = 1; s < l_lp; s++) begin
                stub_v[s] <= stub_v[s-1];
                stub_t[s] <= stub_t[s-1];
                stub_r[s] <= stub_r[s-1];
            end
        end
    end

    assign fma_v_i    = stub_v[l_lp-1] | inject;
    assign fma_res_i  = stub_r[l_lp-1];
    assign fma_type_i = stub_t[l_lp-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic opc, input logic [31:0] a,
                           input logic [31:0] b, input logic [47:0] c);
        req_opcode[i]    = opc;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_c[48*i +: 48] = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; req_v = '1; req_opcode = '0; req_a = '0; req_b = '0; req_c = '0;
        drain = 1'b0; inject = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fma_v", fma_v_o, 0);
        check("rst_yumi", req_yumi, 0);
        check("rst_resp_v", resp_v, 0);
        check("rst_res", resp_res, 0);
        check("rst_err", error, 0);
        check("rst_idle", idle, 1);
        check("rst_a", fma_a_o, 0);
        req_v = '0;
        reset_i = 1'b0;
        next();

        // single multiply from requester 0
        set_req(0, 1'b0, 3, 5, 0);
        req_v = 4'b0001; #1;
        check("mul_yumi", req_yumi, 4'b0001);
        next(); req_v = '0;
        check("mul_fma_v", fma_v_o, 1);
        check("mul_a", fma_a_o, 3);
        check("mul_b", fma_b_o, 5);
        check("mul_opc", fma_opcode_o, 0);
        check("mul_idle_issue", idle, 0);
        next();
        check("mul_fma_v_pulse", fma_v_o, 0);
        next(); next();
        check("mul_idle_busy", idle, 0);
        check("mul_resp_early", resp_v, 0);
        next();
        check("mul_resp_v", resp_v, 4'b0001);
        check("mul_res", resp_res, 15);
        check("mul_type", resp_type, 0);
        check("mul_idle_done", idle, 1);
        next();
        check("mul_resp_clear", resp_v, 0);
        check("mul_res_hold", resp_res, 15);

        // add from requester 2 (pointer is 1)
        set_req(2, 1'b1, 1, 2, 3);
        req_v = 4'b0100; #1;
        check("add_yumi", req_yumi, 4'b0100);
        next(); req_v = '0;
        check("add_opc", fma_opcode_o, 1);
        check("add_c", fma_c_o, 3);
        repeat (4) next();
        check("add_resp_v", resp_v, 4'b0100);
        check("add_res", resp_res, 6);
        check("add_type", resp_type, 1);

        // pointer wrap: pointer is 3
        set_req(0, 1'b0, 7, 1, 0);
        set_req(3, 1'b0, 9, 1, 0);
        req_v = 4'b1001; #1;
        check("wrap_first", req_yumi, 4'b1000);
        next(); req_v = 4'b0001; #1;
        check("wrap_second", req_yumi, 4'b0001);
        next(); req_v = '0;
        repeat (3) next();
        check("wrap_resp3_v", resp_v, 4'b1000);
        check("wrap_resp3_res", resp_res, 9);
        next();
        check("wrap_resp0_v", resp_v, 4'b0001);
        check("wrap_resp0_res", resp_res, 7);

        // pointer is 1; a lone grant to 3 brings it back to 0
        req_v = 4'b1000; #1;
        check("pre_yumi", req_yumi, 4'b1000);
        next(); req_v = '0;
        repeat (5) next();

        // all requesters valid: strict rotation
        for (int i = 0; i < n_lp; i++) set_req(i, 1'b0, 32'(i + 1), 10, 0);
        for (int k = 0; k < 13; k++) begin
            req_v = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) check($sformatf("rot_yumi%0d", k), req_yumi, 64'(1 << (k % 4)));
            if (k >= 5) begin
                check($sformatf("rot_resp_v%0d", k - 5), resp_v, 64'(1 << ((k - 5) % 4)));
                check($sformatf("rot_res%0d", k - 5), resp_res, 64'(10 * ((k - 5) % 4 + 1)));
            end
            next();
        end

        // drain with two ops in flight and requests pending
        req_v = 4'b0011; #1;
        check("drain_y0", req_yumi, 4'b0001);
        next(); #1;
        check("drain_y1", req_yumi, 4'b0010);
        next(); drain = 1'b1; #1;
        check("drain_y2", req_yumi, 0);
        check("drain_last_issue", fma_v_o, 1);
        next(); #1;
        check("drain_y3", req_yumi, 0);
        check("drain_no_issue", fma_v_o, 0);
        next(); next();
        check("drain_resp0_v", resp_v, 4'b0001);
        check("drain_resp0_res", resp_res, 10);
        check("drain_idle_busy", idle, 0);
        next();
        check("drain_resp1_v", resp_v, 4'b0010);
        check("drain_resp1_res", resp_res, 20);
        check("drain_idle", idle, 1);
        drain = 1'b0; req_v = '0;

        // spurious datapath valid
        next(); inject = 1'b1;
        next(); inject = 1'b0;
        check("err_set", error, 1);
        check("err_no_resp", resp_v, 0);
        repeat (3) next();
        check("err_sticky", error, 1);

        // reset with ops in flight (pointer is 2)
        req_v = 4'b0011; #1;
        check("mr_y0", req_yumi, 4'b0001);
        next(); #1;
        check("mr_y1", req_yumi, 4'b0010);
        next(); req_v = 4'b1111;
        check("mr_busy", fma_v_o, 1);
        reset_i = 1'b1; #1;
        check("mr_fma_v", fma_v_o, 0);
        check("mr_idle", idle, 1);
        check("mr_err", error, 0);
        check("mr_yumi", req_yumi, 0);
        check("mr_res", resp_res, 0);
        next(); next();
        reset_i = 1'b0; req_v = '0;
        seen = '0;
        repeat (8) begin
            next();
            seen = seen | resp_v;
        end
        check("mr_no_resp", seen, 0);
        check("mr_err_after", error, 0);

        // pointer restarts at 0
        req_v = 4'b1111; #1;
        check("rst_ptr", req_yumi, 4'b0001);
        next(); req_v = '0;
        repeat (6) next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
